wb_bus_arbiter: RTL and testbench

- Round-robin arbiter that lets N Wishbone Classic masters share one master port.
- The shared port drives the existing single-master shared-bus interconnect, which fans out to the slaves.
- Ownership is held for a whole CYC cycle. Slaves must see clean STB/CYC with no owner change mid-cycle.
- A watchdog ends any transfer whose slave never acknowledges, returning ERR to the owning master so the bus cannot lock up.

---
 rtl/wb_bus_arbiter.sv | 137 +++++++++++++
 tb/tb_wb_bus_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_bus_arbiter.sv
// Round-robin arbiter sharing one Wishbone Classic master port among N masters.
// The owner keeps the bus for its whole CYC. A watchdog aborts strobes that are
// never acknowledged and returns ERR to the owner.
module wb_bus_arbiter #(
    parameter int N       = 4,
    parameter int AW      = 2,
    parameter int DW      = 8,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    m_cyc,
    input  logic [N-1:0]    m_stb,
    input  logic [N-1:0]    m_we,
    input  logic [N*AW-1:0] m_addr,
    input  logic [N*DW-1:0] m_data_m,
    output logic [DW-1:0]   m_data_s,
    output logic [N-1:0]    m_ack,
    output logic [N-1:0]    m_err,
    output logic            s_cyc,
    output logic            s_stb,
    output logic            s_we,
    output logic [AW-1:0]   s_addr,
    output logic [DW-1:0]   s_data_m,
    input  logic [DW-1:0]   s_data_s,
    input  logic            s_ack,
    output logic [N-1:0]    gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int SW = PW + 1;
    localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

    state_t        state, state_nxt;
    // ptr is both the round-robin pointer and the current owner: a grant
    // moves the pointer onto the winner, so no separate owner register exists.
    logic [PW-1:0] ptr, ptr_nxt;
    logic [WW-1:0] wdog, wdog_nxt;
    logic [PW-1:0] win;
    logic          win_vld;
    logic [SW-1:0] sum;
    logic [PW-1:0] idx;

    logic [AW-1:0] addr_a [N];
    logic [DW-1:0] wd_a   [N];

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign addr_a[i] = m_addr[i*AW +: AW];
        assign wd_a[i]   = m_data_m[i*DW +: DW];
    end

    assign m_data_s = s_data_s;

    // Round-robin search: first requester above the pointer, wrapping mod N.
    // Iterating downward lets the nearest candidate overwrite farther ones.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int i = N; i >= 1; i--) begin
            sum = {1'b0, ptr} + SW'(i);
            if (sum >= SW'(N)) sum = sum - SW'(N);
            idx = sum[PW-1:0];
            if (m_cyc[idx]) begin
                win     = idx;
                win_vld = 1'b1;
            end
        end
    end

    // Next state plus the shared-port mux, ack/err steering and watchdog.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        wdog_nxt  = '0;
        gnt       = '0;
        s_cyc     = 1'b0;
        s_stb     = 1'b0;
        s_we      = 1'b0;
        s_addr    = '0;
        s_data_m  = '0;
        m_ack     = '0;
        m_err     = '0;
        case (state)
            IDLE: begin
                if (win_vld) begin
                    ptr_nxt   = win;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                gnt[ptr]   = 1'b1;
                s_cyc      = m_cyc[ptr];
                s_stb      = m_stb[ptr];
                s_we       = m_we[ptr];
                s_addr     = addr_a[ptr];
                s_data_m   = wd_a[ptr];
                m_ack[ptr] = s_ack;
                if (m_stb[ptr] && !s_ack)
                    wdog_nxt = (wdog == WW'(TIMEOUT)) ? wdog : wdog + 1'b1;
                // Firing on the last wait cycle itself; an ack in that same
                // cycle takes precedence because s_ack gates the condition.
                if ((TIMEOUT != 0) && m_stb[ptr] && !s_ack &&
                    (wdog == WW'(TIMEOUT - 1))) begin
                    s_cyc      = 1'b0;
                    s_stb      = 1'b0;
                    m_err[ptr] = 1'b1;
                    state_nxt  = ABORT;
                end else if (!m_cyc[ptr]) begin
                    state_nxt = IDLE;
                end
            end
            ABORT: begin
                gnt[ptr] = 1'b1;
                if (!m_cyc[ptr]) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, pointer and watchdog registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= PW'(N - 1);
            wdog  <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            wdog  <= wdog_nxt;
        end
    end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Randomized bench for wb_bus_arbiter: a cycle-level reference model pushes the
// expected outputs of every cycle into a queue; a negedge monitor pops them and
// compares against the DUT. Directed phases add grant-order and event checks.
module tb_wb_bus_arbiter;
    localparam int N = 4, AW = 2, DW = 8, TIMEOUT = 15;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    m_cyc = '0, m_stb = '0, m_we = '0;
    logic [N*AW-1:0] m_addr = '0;
    logic [N*DW-1:0] m_data_m = '0;
    logic [DW-1:0]   m_data_s;
    logic [N-1:0]    m_ack, m_err, gnt;
    logic            s_cyc, s_stb, s_we;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_data_m;
    logic [DW-1:0]   s_data_s = '0;
    logic            s_ack = 1'b0;

    wb_bus_arbiter #(.N(N), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we),
        .m_addr(m_addr), .m_data_m(m_data_m), .m_data_s(m_data_s),
        .m_ack(m_ack), .m_err(m_err), .s_cyc(s_cyc), .s_stb(s_stb),
        .s_we(s_we), .s_addr(s_addr), .s_data_m(s_data_m),
        .s_data_s(s_data_s), .s_ack(s_ack), .gnt(gnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0]  gnt, ack, err;
        logic          cyc, stb, we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd, rd;
    } exp_t;

    exp_t  expq[$];
    int    checks = 0, errors = 0, cyc_no = 0;
    string phase = "reset";

    // reference model: owner -1 means nobody holds the bus
    int own = -1, ptr_m = N - 1, waits = 0;
    bit abrt = 1'b0;
    int n_own = -1, n_ptr = N - 1, n_waits = 0;
    bit n_abrt = 1'b0;
    logic [N-1:0] last_ack = '0, last_err = '0;

    // stimulus controls
    bit   act[N];
    int   beats[N], budget[N], hold[N];
    logic [N-1:0] en = '0;
    int   start_pct = 100, minb = 1, maxb = 1;
    int   ack_mode = 0, ack_pct = 50, ack_at = 2;
    bit   fix_beat = 1'b0, rd_rand = 1'b1, rst_req = 1'b1;
    logic [DW-1:0] rd_fix = '0;

    // monitor-side observations
    int   gord[$];
    int   errs_seen = 0, acks3_seen = 0;
    logic [N-1:0] prev_gnt = '0;
    int   rr_exp[5] = '{0, 1, 2, 3, 0};

    task automatic check_int(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", nm, got, want);
        end
    endtask

    task automatic new_beat(input int i);
        if (fix_beat) begin
            m_addr[i*AW +: AW] = AW'(1);
            m_we[i] = 1'b0;
        end else begin
            m_addr[i*AW +: AW] = AW'($urandom);
            m_we[i] = 1'($urandom_range(0, 1));
        end
        m_data_m[i*DW +: DW] = DW'($urandom);
    endtask

    // Masters react to the acks/errs the model predicted for the previous cycle.
    task automatic drive_masters();
        for (int i = 0; i < N; i++) begin
            if (act[i]) begin
                if (hold[i] > 0) begin
                    hold[i]--;
                    if (hold[i] == 0) begin act[i] = 1'b0; m_cyc[i] = 1'b0; end
                end else if (last_err[i]) begin
                    m_stb[i] = 1'b0;
                    hold[i]  = $urandom_range(1, 3);
                end else if (last_ack[i] && m_stb[i]) begin
                    beats[i]--;
                    if (beats[i] == 0) begin
                        act[i] = 1'b0; m_cyc[i] = 1'b0; m_stb[i] = 1'b0;
                    end else begin
                        m_stb[i] = 1'($urandom_range(0, 1));
                        new_beat(i);
                    end
                end else if (!m_stb[i] && $urandom_range(0, 1) == 1) begin
                    m_stb[i] = 1'b1;
                    new_beat(i);
                end
            end else if (en[i] && budget[i] > 0 && !m_cyc[i] &&
                         $urandom_range(0, 99) < start_pct) begin
                act[i] = 1'b1; budget[i]--; hold[i] = 0;
                beats[i] = $urandom_range(minb, maxb);
                m_cyc[i] = 1'b1; m_stb[i] = 1'b1;
                new_beat(i);
            end
        end
    endtask

    task automatic drive_slave();
        case (ack_mode)
            0: s_ack = ($urandom_range(0, 99) < ack_pct);
            1: s_ack = 1'b0;
            2: s_ack = 1'b1;
            default: s_ack = (waits == ack_at - 1);
        endcase
        s_data_s = rd_rand ? DW'($urandom) : rd_fix;
    endtask

    // Expected outputs for this cycle from the arbitration rules, and next state.
    task automatic model();
        exp_t e;
        bit   st;
        e = '0;
        e.rd = s_data_s;
        n_own = own; n_abrt = abrt; n_ptr = ptr_m; n_waits = 0;
        if (own < 0) begin
            for (int d = 1; d <= N; d++) begin
                if (m_cyc[(ptr_m + d) % N]) begin
                    n_own = (ptr_m + d) % N;
                    n_ptr = n_own;
                    break;
                end
            end
        end else if (abrt) begin
            e.gnt[own] = 1'b1;
            if (!m_cyc[own]) begin n_own = -1; n_abrt = 1'b0; end
        end else begin
            st = m_stb[own];
            e.gnt[own] = 1'b1;
            e.cyc  = m_cyc[own];
            e.stb  = st;
            e.we   = m_we[own];
            e.addr = m_addr[own*AW +: AW];
            e.wd   = m_data_m[own*DW +: DW];
            e.ack[own] = s_ack;
            if (TIMEOUT > 0 && st && !s_ack && waits + 1 >= TIMEOUT) begin
                e.cyc = 1'b0; e.stb = 1'b0;
                e.err[own] = 1'b1;
                n_abrt = 1'b1;
            end else begin
                n_waits = (st && !s_ack) ? waits + 1 : 0;
                if (!m_cyc[own]) n_own = -1;
            end
        end
        if (!rst_n) begin
            n_own = -1; n_abrt = 1'b0; n_ptr = N - 1; n_waits = 0;
        end
        last_ack = e.ack;
        last_err = e.err;
        expq.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            own = n_own; abrt = n_abrt; ptr_m = n_ptr; waits = n_waits;
            rst_n = !rst_req;
            drive_masters();
            drive_slave();
            model();
            cyc_no++;
        end
    endtask

    // Scoreboard monitor plus grant-order / event bookkeeping.
    always @(negedge clk) begin
        exp_t e, d;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            d.gnt = gnt; d.ack = m_ack; d.err = m_err; d.cyc = s_cyc;
            d.stb = s_stb; d.we = s_we; d.addr = s_addr; d.wd = s_data_m;
            d.rd = m_data_s;
            checks++;
            if (d !== e) begin
                errors++;
                $display("FAIL outputs %s cyc%0d: got gnt=%b ack=%b err=%b cyc=%b stb=%b we=%b a=%h wd=%h rd=%h; want gnt=%b ack=%b err=%b cyc=%b stb=%b we=%b a=%h wd=%h rd=%h",
                         phase, cyc_no, d.gnt, d.ack, d.err, d.cyc, d.stb, d.we, d.addr, d.wd, d.rd,
                         e.gnt, e.ack, e.err, e.cyc, e.stb, e.we, e.addr, e.wd, e.rd);
            end
        end
        if (gnt != 0 && gnt != prev_gnt)
            for (int k = 0; k < N; k++) if (gnt[k]) gord.push_back(k);
        prev_gnt = gnt;
        if (|m_err) errs_seen++;
        if (m_ack[3]) acks3_seen++;
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            act[i] = 1'b0; beats[i] = 0; budget[i] = 0; hold[i] = 0;
        end
        @(posedge clk);
        step(3);
        rst_req = 1'b0;

        phase = "single";
        fix_beat = 1'b1; rd_rand = 1'b0; rd_fix = 8'hA5;
        ack_mode = 3; ack_at = 2; en = 4'b0100; budget[2] = 1;
        step(10);
        fix_beat = 1'b0; rd_rand = 1'b1; en = '0;

        phase = "round_robin";
        ack_mode = 0; ack_pct = 60;
        for (int i = 0; i < N; i++) budget[i] = 2;
        en = 4'hF; rst_req = 1'b1;
        gord.delete();
        step(1);
        rst_req = 1'b0;
        step(80);
        for (int k = 0; k < 5; k++)
            check_int($sformatf("rr_order[%0d]", k), (k < gord.size()) ? gord[k] : -1, rr_exp[k]);
        en = '0;

        phase = "locked";
        rst_req = 1'b1; step(1); rst_req = 1'b0;
        gord.delete();
        minb = 3; maxb = 3; ack_pct = 50;
        budget[1] = 1; budget[0] = 1; en = 4'b0010;
        step(3);
        en = 4'b0011;
        step(40);
        check_int("locked_count", gord.size(), 2);
        check_int("locked_first", (gord.size() > 0) ? gord[0] : -1, 1);
        check_int("locked_second", (gord.size() > 1) ? gord[1] : -1, 0);
        en = '0;

        phase = "timeout";
        minb = 1; maxb = 1; ack_mode = 1; en = 4'b1000; budget[3] = 1;
        errs_seen = 0;
        step(30);
        check_int("timeout_err_pulses", errs_seen, 1);

        phase = "ack_on_15";
        ack_mode = 3; ack_at = 15; budget[3] = 1;
        errs_seen = 0; acks3_seen = 0;
        step(30);
        check_int("ack15_err_pulses", errs_seen, 0);
        check_int("ack15_acks", acks3_seen, 1);
        en = '0;

        phase = "reset_mid";
        ack_mode = 1; minb = 4; maxb = 4;
        en = 4'b0010; budget[1] = 1;
        step(3);
        en = 4'b0011; budget[0] = 1;
        step(2);
        errs_seen = 0;
        rst_req = 1'b1; step(1); rst_req = 1'b0;
        gord.delete();
        ack_mode = 0; ack_pct = 50;
        step(60);
        check_int("reset_mid_first_grant", (gord.size() > 0) ? gord[0] : -1, 0);
        check_int("reset_mid_err_pulses", errs_seen, 0);
        en = '0;

        phase = "continuous_ack";
        ack_mode = 2; en = 4'b0001; budget[0] = 1;
        errs_seen = 0;
        step(30);
        check_int("cont_ack_err_pulses", errs_seen, 0);
        en = '0;

        phase = "random";
        start_pct = 30; minb = 1; maxb = 4;
        for (int i = 0; i < N; i++) budget[i] = 1000;
        for (int seg = 0; seg < 8; seg++) begin
            ack_mode = (seg % 4 == 1) ? 1 : ((seg % 4 == 3) ? 2 : 0);
            ack_pct  = $urandom_range(20, 90);
            en       = N'($urandom_range(1, 15));
            for (int k = 0; k < ((ack_mode == 1) ? 150 : 400); k++) begin
                rst_req = ($urandom_range(0, 299) == 0);
                step(1);
            end
        end
        rst_req = 1'b0;
        @(negedge clk); #1;
        check_int("scoreboard_drained", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
